pe_mac_cfg: RTL and testbench
=============================

// Module: pe_mac_cfg
// PURPOSE
//  Next-generation systolic-array processing element: signed MAC with a selectable
//  weight-stationary (WS) or output-stationary (OS) dataflow, a valid handshake,
//  systolic input forwarding, a daisy-chained weight preload and optional saturation.
//  Tiled in rows/columns of the array; acc_in/acc_out chain vertically in WS mode.
// PARAMETERS
//  DATA_WIDTH    8   width of signed inp/wgt operands
//  PE_OUT_WIDTH  21  width of signed accumulator / partial sum
//  SATURATE      1   1: clamp on overflow; 0: two's-complement wrap
//  CNT_WIDTH     8   width of OS term counter
// PORTS
//  clk           in   1             rising-edge clock
//  rst_n         in   1             asynchronous active-low reset
//  mode          in   1             0 = WS, 1 = OS
//  clear         in   1             sync clear of accumulator, counter, ovf
//  wgt_load      in   1             shift wgt_in into weight register
//  wgt_in        in   DATA_WIDTH    signed weight (preload in WS, streamed in OS)
//  wgt_out       out  DATA_WIDTH    current weight register (chain to next PE)
//  inp_valid     in   1             inp_in (and wgt_in in OS) valid this cycle
//  inp_last      in   1             OS: final term of current dot product
//  inp_in        in   DATA_WIDTH    signed activation
//  inp_out       out  DATA_WIDTH    inp_in delayed 1 cycle (to right neighbour)
//  inp_valid_out out  1             inp_valid delayed 1 cycle
//  acc_in        in   PE_OUT_WIDTH  WS partial sum from upper PE
//  acc_out       out  PE_OUT_WIDTH  result / partial sum
//  acc_valid     out  1             acc_out valid (1-cycle pulse per result)
//  term_cnt      out  CNT_WIDTH     OS terms accumulated so far
//  ovf           out  1             sticky: overflow occurred since clear/reset
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs and internal regs 0; FSM -> IDLE.
//  Forwarding (both modes): inp_out<=inp_in, inp_valid_out<=inp_valid every cycle.
//  Weight reg: wgt_load=1 -> wgt_reg<=wgt_in; wgt_out=wgt_reg (combinational);
//   N-PE chain loads in N cycles. wgt_load ignores inp_valid.
//  Arithmetic: product = inp*w, full 2*DATA_WIDTH signed; sum computed at
//   PE_OUT_WIDTH+1 bits; out of range -> ovf<=1 and clamp to
//   [-2^(W-1), 2^(W-1)-1] if SATURATE else keep low W bits.
//  WS (mode=0), latency 1: inp_valid=1 -> acc_out<=sat(inp_in*wgt_reg+acc_in),
//   acc_valid<=1; inp_valid=0 -> acc_valid<=0, acc_out holds. Same-cycle
//   wgt_load+inp_valid uses OLD wgt_reg.
//  OS (mode=1) FSM IDLE/ACC:
//   IDLE: inp_valid -> acc_reg<=product, term_cnt<=1, ->ACC (or emit if inp_last).
//   ACC: inp_valid -> acc_reg<=sat(acc_reg+inp_in*wgt_in), term_cnt+1.
//   inp_valid&inp_last (either state): acc_out<=final sum, acc_valid<=1 next cycle,
//    acc_reg<=0, term_cnt<=0, ->IDLE; back-to-back vectors need no gap.
//   term_cnt saturates at all-ones (does not wrap); acc_in ignored in OS.
//  clear=1: acc_reg, term_cnt, ovf, acc_valid <=0, FSM->IDLE; wins over inp_valid
//   same cycle; wgt_reg and forwarding unaffected.
//  mode change: treated as implicit clear on the cycle mode differs from its
//   registered copy (partial OS sum discarded, no acc_valid).
//  ovf only cleared by clear or rst_n; acc_valid never asserted two cycles for
//   one result.
// TESTING
//  1 Reset mid-OS-accumulation (rst_n low 1 cyc) -> all outputs 0, next vector clean.
//  2 WS: preload w=3, inp=5, acc_in=10 valid -> next cycle acc_out=25, acc_valid=1.
//  3 WS chain: 4 PEs, wgt_load 4 cycles with 1,2,3,4 -> PE0 holds 4, PE3 holds 1.
//  4 OS: pairs (2,3),(4,-1),(-5,2) last on 3rd -> acc_out=-8 pulse, term_cnt 0 after;
//    next vector starts next cycle without gap.
//  5 Saturation: W=21, acc_in=1048575, inp=127,wgt=127 -> acc_out=1048575, ovf=1;
//    SATURATE=0 -> wrapped value, ovf=1; clear -> ovf=0.
//  6 clear and inp_valid same cycle, and mode toggle mid-vector -> no acc_valid, acc=0.

Source files
------------

// File: rtl/pe_mac_cfg.sv
// pe_mac_cfg: systolic-array processing element.
// Signed MAC with a weight-stationary (mode=0) or output-stationary (mode=1)
// dataflow, one-cycle activation forwarding, a daisy-chained weight register
// and optional saturation of the accumulator on overflow.
module pe_mac_cfg #(
    parameter int DATA_WIDTH   = 8,
    parameter int PE_OUT_WIDTH = 21,
    parameter int SATURATE     = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic                    clear,
    input  logic                    wgt_load,
    input  logic [DATA_WIDTH-1:0]   wgt_in,
    output logic [DATA_WIDTH-1:0]   wgt_out,
    input  logic                    inp_valid,
    input  logic                    inp_last,
    input  logic [DATA_WIDTH-1:0]   inp_in,
    output logic [DATA_WIDTH-1:0]   inp_out,
    output logic                    inp_valid_out,
    input  logic [PE_OUT_WIDTH-1:0] acc_in,
    output logic [PE_OUT_WIDTH-1:0] acc_out,
    output logic                    acc_valid,
    output logic [CNT_WIDTH-1:0]    term_cnt,
    output logic                    ovf
);

    localparam int W  = PE_OUT_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   wgt_q, wgt_d;
    logic [DATA_WIDTH-1:0]   inp_out_q, inp_out_d;
    logic                    inp_valid_out_q, inp_valid_out_d;
    logic [W-1:0]            acc_out_q, acc_out_d;
    logic                    acc_valid_q, acc_valid_d;
    logic [W-1:0]            acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    mode_q, mode_d;

    logic signed [PW-1:0]    wsProd;
    logic signed [PW-1:0]    osProd;
    logic [W:0]              wsSum;
    logic [W:0]              osSum;
    logic [W:0]              osBase;
    logic [CNT_WIDTH-1:0]    cntBase;
    logic [CNT_WIDTH-1:0]    cntInc;
    logic                    flush;

    // A W+1 bit sum is out of range when its two top bits disagree.
    function automatic logic sumOvf(input logic [W:0] s);
        return s[W] ^ s[W-1];
    endfunction

    // Bring a W+1 bit sum back to W bits: clamp when saturating, else wrap.
    function automatic logic [W-1:0] fitSum(input logic [W:0] s);
        if (sumOvf(s) && (SATURATE != 0)) begin
            return s[W] ? ACC_MIN : ACC_MAX;
        end
        return s[W-1:0];
    endfunction

    // Datapath, dataflow selection and OS sequencing; a mode change behaves as a clear.
    always_comb begin
        wsProd          = $signed(inp_in) * $signed(wgt_q);
        osProd          = $signed(inp_in) * $signed(wgt_in);
        wsSum           = {{(W+1-PW){wsProd[PW-1]}}, wsProd} + {acc_in[W-1], acc_in};
        osBase          = (state_q == ACC) ? {acc_q[W-1], acc_q} : '0;
        osSum           = {{(W+1-PW){osProd[PW-1]}}, osProd} + osBase;
        cntBase         = (state_q == ACC) ? cnt_q : '0;
        cntInc          = (&cntBase) ? cntBase : cntBase + 1'b1;
        flush           = clear || (mode != mode_q);

        state_d         = state_q;
        wgt_d           = wgt_load ? wgt_in : wgt_q;
        inp_out_d       = inp_in;
        inp_valid_out_d = inp_valid;
        acc_out_d       = acc_out_q;
        acc_valid_d     = 1'b0;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        ovf_d           = ovf_q;
        mode_d          = mode;

        if (flush) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end else if (!mode) begin
            if (inp_valid) begin
                acc_out_d   = fitSum(wsSum);
                acc_valid_d = 1'b1;
                ovf_d       = ovf_q | sumOvf(wsSum);
            end
        end else if (inp_valid) begin
            ovf_d = ovf_q | sumOvf(osSum);
            if (inp_last) begin
                acc_out_d   = fitSum(osSum);
                acc_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = IDLE;
            end else begin
                acc_d   = fitSum(osSum);
                cnt_d   = cntInc;
                state_d = ACC;
            end
        end
    end

    // State and pipeline registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            wgt_q           <= '0;
            inp_out_q       <= '0;
            inp_valid_out_q <= 1'b0;
            acc_out_q       <= '0;
            acc_valid_q     <= 1'b0;
            acc_q           <= '0;
            cnt_q           <= '0;
            ovf_q           <= 1'b0;
            mode_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wgt_q           <= wgt_d;
            inp_out_q       <= inp_out_d;
            inp_valid_out_q <= inp_valid_out_d;
            acc_out_q       <= acc_out_d;
            acc_valid_q     <= acc_valid_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            ovf_q           <= ovf_d;
            mode_q          <= mode_d;
        end
    end

    assign wgt_out       = wgt_q;
    assign inp_out       = inp_out_q;
    assign inp_valid_out = inp_valid_out_q;
    assign acc_out       = acc_out_q;
    assign acc_valid     = acc_valid_q;
    assign term_cnt      = cnt_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_pe_mac_cfg.sv
// tb_pe_mac_cfg: directed bench for pe_mac_cfg with hand-computed expectations.
// Instances: a saturating PE, a wrapping PE sharing its inputs, and a
// four-PE weight chain.
module tb_pe_mac_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        clear = 1'b0;
    logic        wgt_load = 1'b0;
    logic [7:0]  wgt_in = '0;
    logic        inp_valid = 1'b0;
    logic        inp_last = 1'b0;
    logic [7:0]  inp_in = '0;
    logic [20:0] acc_in = '0;

    logic [7:0]  wgt_out, inp_out;
    logic        inp_valid_out, acc_valid, ovf;
    logic [20:0] acc_out;
    logic [7:0]  term_cnt;

    logic [7:0]  wWgtOut, wInpOut;
    logic        wInpValidOut, wAccValid, wOvf;
    logic [20:0] wAccOut;
    logic [7:0]  wTermCnt;

    logic        chainLoad = 1'b0;
    logic [7:0]  chainIn = '0;
    logic [7:0]  chainWgtIn [4];
    logic [7:0]  chainWgt [4];
    logic [7:0]  chainInpOut [4];
    logic        chainInpValidOut [4];
    logic [20:0] chainAccOut [4];
    logic        chainAccValid [4];
    logic [7:0]  chainTermCnt [4];
    logic        chainOvf [4];

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    pe_mac_cfg #(.DATA_WIDTH(8), .PE_OUT_WIDTH(21), .SATURATE(1), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .clear(clear),
        .wgt_load(wgt_load), .wgt_in(wgt_in), .wgt_out(wgt_out),
        .inp_valid(inp_valid), .inp_last(inp_last), .inp_in(inp_in),
        .inp_out(inp_out), .inp_valid_out(inp_valid_out),
        .acc_in(acc_in), .acc_out(acc_out), .acc_valid(acc_valid),
        .term_cnt(term_cnt), .ovf(ovf)
    );

    pe_mac_cfg #(.DATA_WIDTH(8), .PE_OUT_WIDTH(21), .SATURATE(0), .CNT_WIDTH(8)) dutWrap (
        .clk(clk), .rst_n(rst_n), .mode(mode), .clear(clear),
        .wgt_load(wgt_load), .wgt_in(wgt_in), .wgt_out(wWgtOut),
        .inp_valid(inp_valid), .inp_last(inp_last), .inp_in(inp_in),
        .inp_out(wInpOut), .inp_valid_out(wInpValidOut),
        .acc_in(acc_in), .acc_out(wAccOut), .acc_valid(wAccValid),
        .term_cnt(wTermCnt), .ovf(wOvf)
    );

    assign chainWgtIn[0] = chainIn;

    for (genvar k = 0; k < 4; k++) begin : gChain
        if (k > 0) begin : gLink
            assign chainWgtIn[k] = chainWgt[k-1];
        end
        pe_mac_cfg #(.DATA_WIDTH(8), .PE_OUT_WIDTH(21), .SATURATE(1), .CNT_WIDTH(8)) pe (
            .clk(clk), .rst_n(rst_n), .mode(mode), .clear(clear),
            .wgt_load(chainLoad), .wgt_in(chainWgtIn[k]), .wgt_out(chainWgt[k]),
            .inp_valid(inp_valid), .inp_last(inp_last), .inp_in(inp_in),
            .inp_out(chainInpOut[k]), .inp_valid_out(chainInpValidOut[k]),
            .acc_in(acc_in), .acc_out(chainAccOut[k]), .acc_valid(chainAccValid[k]),
            .term_cnt(chainTermCnt[k]), .ovf(chainOvf[k])
        );
    end

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Change dataflow and let the implicit-clear cycle pass with no valid data.
    task automatic setMode(input logic m);
        if (mode != m) begin
            mode      = m;
            inp_valid = 1'b0;
            inp_last  = 1'b0;
            tick();
        end
    endtask

    // Present one OS term (activation, streamed weight, last flag) for a cycle.
    task automatic osTerm(input int a, input int b, input logic last);
        inp_valid = 1'b1;
        inp_in    = 8'(a);
        wgt_in    = 8'(b);
        inp_last  = last;
        tick();
    endtask

    task automatic test_powerup();
        vecCount++;
        if (acc_out !== 21'd0 || acc_valid !== 1'b0 || term_cnt !== 8'd0 || ovf !== 1'b0 ||
            wgt_out !== 8'd0 || inp_out !== 8'd0 || inp_valid_out !== 1'b0) begin
            $display("[TB] FAIL powerup: acc_out=%0d acc_valid=%b term_cnt=%0d ovf=%b wgt_out=%0d inp_out=%0d ivo=%b, required all 0",
                     acc_out, acc_valid, term_cnt, ovf, wgt_out, inp_out, inp_valid_out);
            errCount++;
        end
    endtask

    task automatic test_ws();
        setMode(1'b0);
        wgt_load = 1'b1; wgt_in = 8'd3; inp_valid = 1'b0;
        tick();
        vecCount++;
        if (wgt_out !== 8'd3 || acc_valid !== 1'b0) begin
            $display("[TB] FAIL ws_preload: wgt_out=%0d acc_valid=%b, required 3/0", wgt_out, acc_valid);
            errCount++;
        end
        wgt_load = 1'b0; inp_in = 8'd5; acc_in = 21'd10; inp_valid = 1'b1;
        tick();
        vecCount++;
        if (acc_out !== 21'd25 || acc_valid !== 1'b1) begin
            $display("[TB] FAIL ws_mac: acc_out=%0d acc_valid=%b, required 25/1", $signed(acc_out), acc_valid);
            errCount++;
        end
        vecCount++;
        if (inp_out !== 8'd5 || inp_valid_out !== 1'b1) begin
            $display("[TB] FAIL ws_forward: inp_out=%0d ivo=%b, required 5/1", inp_out, inp_valid_out);
            errCount++;
        end
        wgt_load = 1'b1; wgt_in = 8'd7; inp_in = 8'd2; acc_in = 21'd1;
        tick();
        vecCount++;
        if (acc_out !== 21'd7 || wgt_out !== 8'd7) begin
            $display("[TB] FAIL ws_old_weight: acc_out=%0d wgt_out=%0d, required 7/7", $signed(acc_out), wgt_out);
            errCount++;
        end
        wgt_load = 1'b0; inp_in = 8'(-4); acc_in = 21'(-100);
        tick();
        vecCount++;
        if (acc_out !== 21'(-128) || acc_valid !== 1'b1) begin
            $display("[TB] FAIL ws_negative: acc_out=%0d acc_valid=%b, required -128/1", $signed(acc_out), acc_valid);
            errCount++;
        end
        inp_valid = 1'b0; inp_in = 8'd9;
        tick();
        vecCount++;
        if (acc_out !== 21'(-128) || acc_valid !== 1'b0 || inp_valid_out !== 1'b0 || inp_out !== 8'd9) begin
            $display("[TB] FAIL ws_hold: acc_out=%0d acc_valid=%b ivo=%b inp_out=%0d, required -128/0/0/9",
                     $signed(acc_out), acc_valid, inp_valid_out, inp_out);
            errCount++;
        end
        acc_in = '0;
    endtask

    task automatic test_chain();
        chainLoad = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chainIn = 8'(i);
            tick();
        end
        chainLoad = 1'b0;
        chainIn   = 8'd99;
        tick();
        for (int k = 0; k < 4; k++) begin
            vecCount++;
            if (chainWgt[k] !== 8'(4 - k)) begin
                $display("[TB] FAIL chain_pe%0d: wgt_out=%0d, required %0d", k, chainWgt[k], 4 - k);
                errCount++;
            end
        end
    endtask

    task automatic test_os();
        setMode(1'b1);
        osTerm(2, 3, 1'b0);
        vecCount++;
        if (term_cnt !== 8'd1 || acc_valid !== 1'b0) begin
            $display("[TB] FAIL os_term1: term_cnt=%0d acc_valid=%b, required 1/0", term_cnt, acc_valid);
            errCount++;
        end
        osTerm(4, -1, 1'b0);
        vecCount++;
        if (term_cnt !== 8'd2) begin
            $display("[TB] FAIL os_term2: term_cnt=%0d, required 2", term_cnt);
            errCount++;
        end
        osTerm(-5, 2, 1'b1);
        vecCount++;
        if (acc_out !== 21'(-8) || acc_valid !== 1'b1 || term_cnt !== 8'd0) begin
            $display("[TB] FAIL os_result: acc_out=%0d acc_valid=%b term_cnt=%0d, required -8/1/0",
                     $signed(acc_out), acc_valid, term_cnt);
            errCount++;
        end
        osTerm(3, 3, 1'b0);
        vecCount++;
        if (acc_valid !== 1'b0 || term_cnt !== 8'd1 || acc_out !== 21'(-8)) begin
            $display("[TB] FAIL os_back_to_back_start: acc_valid=%b term_cnt=%0d acc_out=%0d, required 0/1/-8",
                     acc_valid, term_cnt, $signed(acc_out));
            errCount++;
        end
        osTerm(1, -2, 1'b1);
        vecCount++;
        if (acc_out !== 21'd7 || acc_valid !== 1'b1) begin
            $display("[TB] FAIL os_back_to_back_result: acc_out=%0d acc_valid=%b, required 7/1", $signed(acc_out), acc_valid);
            errCount++;
        end
        osTerm(6, -7, 1'b1);
        vecCount++;
        if (acc_out !== 21'(-42) || acc_valid !== 1'b1 || term_cnt !== 8'd0) begin
            $display("[TB] FAIL os_single_term: acc_out=%0d acc_valid=%b term_cnt=%0d, required -42/1/0",
                     $signed(acc_out), acc_valid, term_cnt);
            errCount++;
        end
        for (int i = 0; i < 300; i++) begin
            osTerm(1, 1, 1'b0);
        end
        vecCount++;
        if (term_cnt !== 8'd255 || acc_valid !== 1'b0) begin
            $display("[TB] FAIL os_cnt_saturate: term_cnt=%0d acc_valid=%b, required 255/0", term_cnt, acc_valid);
            errCount++;
        end
        osTerm(1, 1, 1'b1);
        vecCount++;
        if (acc_out !== 21'd301 || acc_valid !== 1'b1 || term_cnt !== 8'd0) begin
            $display("[TB] FAIL os_long_result: acc_out=%0d acc_valid=%b term_cnt=%0d, required 301/1/0",
                     $signed(acc_out), acc_valid, term_cnt);
            errCount++;
        end
        inp_valid = 1'b0; inp_last = 1'b0;
        tick();
        vecCount++;
        if (acc_valid !== 1'b0 || acc_out !== 21'd301) begin
            $display("[TB] FAIL os_pulse_end: acc_valid=%b acc_out=%0d, required 0/301", acc_valid, $signed(acc_out));
            errCount++;
        end
    endtask

    task automatic test_clear_mode();
        setMode(1'b1);
        osTerm(2, 3, 1'b0);
        clear = 1'b1;
        osTerm(4, 4, 1'b0);
        clear = 1'b0;
        vecCount++;
        if (term_cnt !== 8'd0 || acc_valid !== 1'b0) begin
            $display("[TB] FAIL clear_with_valid: term_cnt=%0d acc_valid=%b, required 0/0", term_cnt, acc_valid);
            errCount++;
        end
        osTerm(5, 1, 1'b1);
        vecCount++;
        if (acc_out !== 21'd5 || acc_valid !== 1'b1) begin
            $display("[TB] FAIL clear_discards: acc_out=%0d acc_valid=%b, required 5/1", $signed(acc_out), acc_valid);
            errCount++;
        end
        osTerm(2, 2, 1'b0);
        mode = 1'b0;
        osTerm(3, 1, 1'b1);
        vecCount++;
        if (acc_valid !== 1'b0 || term_cnt !== 8'd0 || acc_out !== 21'd5) begin
            $display("[TB] FAIL mode_toggle: acc_valid=%b term_cnt=%0d acc_out=%0d, required 0/0/5",
                     acc_valid, term_cnt, $signed(acc_out));
            errCount++;
        end
        inp_valid = 1'b0; inp_last = 1'b0;
        setMode(1'b1);
        osTerm(1, 9, 1'b1);
        vecCount++;
        if (acc_out !== 21'd9 || acc_valid !== 1'b1) begin
            $display("[TB] FAIL mode_toggle_discards: acc_out=%0d acc_valid=%b, required 9/1", $signed(acc_out), acc_valid);
            errCount++;
        end
        inp_valid = 1'b0; inp_last = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        setMode(1'b1);
        osTerm(2, 3, 1'b0);
        osTerm(1, 1, 1'b0);
        rst_n = 1'b0;
        #2;
        vecCount++;
        if (acc_out !== 21'd0 || acc_valid !== 1'b0 || term_cnt !== 8'd0 || ovf !== 1'b0 ||
            wgt_out !== 8'd0 || inp_out !== 8'd0 || inp_valid_out !== 1'b0) begin
            $display("[TB] FAIL reset_mid_os: acc_out=%0d acc_valid=%b term_cnt=%0d ovf=%b wgt_out=%0d inp_out=%0d ivo=%b, required all 0",
                     acc_out, acc_valid, term_cnt, ovf, wgt_out, inp_out, inp_valid_out);
            errCount++;
        end
        inp_valid = 1'b0; inp_last = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // The stored mode restarts at WS, so the first OS cycle is a flush.
        tick();
        osTerm(3, 4, 1'b1);
        vecCount++;
        if (acc_out !== 21'd12 || acc_valid !== 1'b1 || term_cnt !== 8'd0) begin
            $display("[TB] FAIL reset_next_vector: acc_out=%0d acc_valid=%b term_cnt=%0d, required 12/1/0",
                     $signed(acc_out), acc_valid, term_cnt);
            errCount++;
        end
        inp_valid = 1'b0; inp_last = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        setMode(1'b0);
        wgt_load = 1'b1; wgt_in = 8'd127;
        tick();
        wgt_load = 1'b0;
        inp_valid = 1'b1; inp_in = 8'd127; acc_in = 21'd1048575;
        tick();
        vecCount++;
        if (acc_out !== 21'd1048575 || ovf !== 1'b1 || acc_valid !== 1'b1) begin
            $display("[TB] FAIL sat_pos: acc_out=%0d ovf=%b acc_valid=%b, required 1048575/1/1", $signed(acc_out), ovf, acc_valid);
            errCount++;
        end
        vecCount++;
        if (wAccOut !== 21'(-1032448) || wOvf !== 1'b1) begin
            $display("[TB] FAIL wrap_pos: acc_out=%0d ovf=%b, required -1032448/1", $signed(wAccOut), wOvf);
            errCount++;
        end
        inp_valid = 1'b0;
        tick();
        vecCount++;
        if (ovf !== 1'b1 || wOvf !== 1'b1) begin
            $display("[TB] FAIL ovf_sticky: ovf=%b wrap_ovf=%b, required 1/1", ovf, wOvf);
            errCount++;
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vecCount++;
        if (ovf !== 1'b0 || wOvf !== 1'b0 || acc_valid !== 1'b0) begin
            $display("[TB] FAIL ovf_clear: ovf=%b wrap_ovf=%b acc_valid=%b, required 0/0/0", ovf, wOvf, acc_valid);
            errCount++;
        end
        inp_valid = 1'b1; inp_in = 8'(-128); acc_in = 21'(-1048576);
        tick();
        vecCount++;
        if (acc_out !== 21'(-1048576) || ovf !== 1'b1) begin
            $display("[TB] FAIL sat_neg: acc_out=%0d ovf=%b, required -1048576/1", $signed(acc_out), ovf);
            errCount++;
        end
        vecCount++;
        if (wAccOut !== 21'd1032320 || wOvf !== 1'b1) begin
            $display("[TB] FAIL wrap_neg: acc_out=%0d ovf=%b, required 1032320/1", $signed(wAccOut), wOvf);
            errCount++;
        end
        inp_valid = 1'b0; acc_in = '0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        test_powerup();
        test_ws();
        test_chain();
        test_os();
        test_clear_mode();
        test_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
